// File: rtl/wb_merge.sv
// rtl/wb_merge.sv - writeback collector merging execute-stage result streams onto scoreboard write ports
//
// Purpose:
//   Each execute result source (0=FLU, 1=load, 2=store, 3=FPU) pushes into its own small FIFO.
//   The sources cannot be stalled. Every cycle, up to NrWbPorts non-empty FIFOs are granted
//   round-robin, popped, and their heads are registered onto the write ports.
//   A push to a full FIFO that is not popped in the same cycle is dropped and sets a sticky overflow flag.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   flush_i                 empties all FIFOs, drops this cycle's pushes, suppresses grants
//   src_valid_i             per-source single-cycle result pulse
//   src_trans_id_i          per-source transaction ID (packed, source 0 in the LSBs)
//   src_result_i            per-source 64-bit result (packed)
//   src_exception_i         per-source exception payload (packed)
//   wb_valid_o              per-port registered write valid
//   wb_trans_id_o           per-port trans ID (zero when the port is idle)
//   wb_result_o             per-port result (zero when the port is idle)
//   wb_exception_o          per-port exception (zero when the port is idle)
//   empty_o                 every FIFO is empty
//   overflow_o              sticky, a push was dropped; cleared by reset only
//   perf_stall_cnt_o        cycles in which a non-empty FIFO went ungranted
//
// Optional feature macro: WB_MERGE_PERF_EN (when undefined, perf_stall_cnt_o is tied to 0)
module wb_merge #(
  parameter int NrSrc       = 4,
  parameter int NrWbPorts   = 2,
  parameter int FifoDepth   = 2,
  parameter int TransIdBits = 3,
  parameter int ExWidth     = 129
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NrSrc-1:0]               src_valid_i,
  input  logic [NrSrc*TransIdBits-1:0]   src_trans_id_i,
  input  logic [NrSrc*64-1:0]            src_result_i,
  input  logic [NrSrc*ExWidth-1:0]       src_exception_i,
  output logic [NrWbPorts-1:0]           wb_valid_o,
  output logic [NrWbPorts*TransIdBits-1:0] wb_trans_id_o,
  output logic [NrWbPorts*64-1:0]        wb_result_o,
  output logic [NrWbPorts*ExWidth-1:0]   wb_exception_o,
  output logic                           empty_o,
  output logic                           overflow_o,
  output logic [31:0]                    perf_stall_cnt_o
);

  localparam int EntW = TransIdBits + 64 + ExWidth;
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth) + 1;
  localparam int SrcW = (NrSrc > 1) ? $clog2(NrSrc) : 1;

  // FIFO storage and bookkeeping; entry layout is {trans_id, result, exception}
  logic [EntW-1:0] r_mem    [NrSrc][FifoDepth];
  logic [PtrW-1:0] r_rd_ptr [NrSrc];
  logic [PtrW-1:0] r_wr_ptr [NrSrc];
  logic [CntW-1:0] r_cnt    [NrSrc];
  logic [SrcW-1:0] r_rr;
  logic            r_overflow;

  logic [NrWbPorts-1:0]             r_wb_valid;
  logic [NrWbPorts*TransIdBits-1:0] r_wb_tid;
  logic [NrWbPorts*64-1:0]          r_wb_res;
  logic [NrWbPorts*ExWidth-1:0]     r_wb_exc;

  logic [EntW-1:0]      w_head [NrSrc];
  logic [NrSrc-1:0]     w_nonempty;
  logic [NrSrc-1:0]     w_full;
  logic [NrSrc-1:0]     w_grant;
  logic [NrSrc-1:0]     w_push;
  logic [NrSrc-1:0]     w_drop;
  logic [SrcW-1:0]      w_port_src [NrWbPorts];
  logic [NrWbPorts-1:0] w_port_vld;
  logic [SrcW-1:0]      w_rr_next;

  always_comb begin
    for (int s = 0; s < NrSrc; s++) begin
      w_head[s]     = r_mem[s][r_rd_ptr[s]];
      w_nonempty[s] = (r_cnt[s] != '0);
      w_full[s]     = (r_cnt[s] == CntW'(FifoDepth));
    end
  end

  // Round-robin scan from r_rr over the pre-push FIFO state; grants fill ports in scan order.
  always_comb begin
    int n_gnt;
    int s;
    n_gnt      = 0;
    s          = 0;
    w_grant    = '0;
    w_port_vld = '0;
    w_rr_next  = r_rr;
    for (int p = 0; p < NrWbPorts; p++) w_port_src[p] = '0;
    if (!flush_i) begin
      for (int i = 0; i < NrSrc; i++) begin
        s = int'(r_rr) + i;
        if (s >= NrSrc) s = s - NrSrc;
        if (w_nonempty[s] && (n_gnt < NrWbPorts)) begin
          w_grant[s]        = 1'b1;
          w_port_src[n_gnt] = SrcW'(s);
          w_port_vld[n_gnt] = 1'b1;
          n_gnt             = n_gnt + 1;
          w_rr_next         = (s == NrSrc - 1) ? '0 : SrcW'(s + 1);
        end
      end
    end
  end

  // A full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    for (int s = 0; s < NrSrc; s++) begin
      w_push[s] = src_valid_i[s] && !flush_i && (!w_full[s] || w_grant[s]);
      w_drop[s] = src_valid_i[s] && !flush_i && w_full[s] && !w_grant[s];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NrSrc; s++) begin
      if (w_push[s]) begin
        r_mem[s][r_wr_ptr[s]] <= {src_trans_id_i[s*TransIdBits +: TransIdBits],
                                  src_result_i[s*64 +: 64],
                                  src_exception_i[s*ExWidth +: ExWidth]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int s = 0; s < NrSrc; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_cnt[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < NrSrc; s++) begin
        if (w_grant[s]) r_rd_ptr[s] <= r_rd_ptr[s] + PtrW'(1);
        if (w_push[s])  r_wr_ptr[s] <= r_wr_ptr[s] + PtrW'(1);
        case ({w_push[s], w_grant[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CntW'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - CntW'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb_valid <= '0;
      r_wb_tid   <= '0;
      r_wb_res   <= '0;
      r_wb_exc   <= '0;
    end else begin
      for (int p = 0; p < NrWbPorts; p++) begin
        if (w_port_vld[p]) begin
          r_wb_valid[p]                           <= 1'b1;
          r_wb_tid[p*TransIdBits +: TransIdBits]  <= w_head[w_port_src[p]][EntW-1 -: TransIdBits];
          r_wb_res[p*64 +: 64]                    <= w_head[w_port_src[p]][ExWidth +: 64];
          r_wb_exc[p*ExWidth +: ExWidth]          <= w_head[w_port_src[p]][ExWidth-1:0];
        end else begin
          r_wb_valid[p]                           <= 1'b0;
          r_wb_tid[p*TransIdBits +: TransIdBits]  <= '0;
          r_wb_res[p*64 +: 64]                    <= '0;
          r_wb_exc[p*ExWidth +: ExWidth]          <= '0;
        end
      end
    end
  end

  // rr holds when nothing is granted, which includes flush cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (|w_grant) r_rr <= w_rr_next;
      if (|w_drop)  r_overflow <= 1'b1;
    end
  end

`ifdef WB_MERGE_PERF_EN
  logic [31:0] r_perf_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_cnt <= '0;
    end else if (!flush_i && |(w_nonempty & ~w_grant)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end
  assign perf_stall_cnt_o = r_perf_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

  assign wb_valid_o     = r_wb_valid;
  assign wb_trans_id_o  = r_wb_tid;
  assign wb_result_o    = r_wb_res;
  assign wb_exception_o = r_wb_exc;
  assign empty_o        = ~|w_nonempty;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_wb_merge.sv
// tb/tb_wb_merge.sv - scoreboard bench for wb_merge with directed vectors
module tb_wb_merge;
  localparam int NS = 4;
  localparam int NP = 2;
  localparam int TB = 3;
  localparam int EW = 129;
`ifdef WB_MERGE_PERF_EN
  localparam int PerfOn = 1;
`else
  localparam int PerfOn = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, flush;
  logic [NS-1:0]      sv;
  logic [NS*TB-1:0]   stid;
  logic [NS*64-1:0]   sres;
  logic [NS*EW-1:0]   sexc;
  logic [NP-1:0]      wb_valid;
  logic [NP*TB-1:0]   wb_tid;
  logic [NP*64-1:0]   wb_res;
  logic [NP*EW-1:0]   wb_exc;
  logic               empty, ovf;
  logic [31:0]        perf;

  wb_merge dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_valid_i(sv), .src_trans_id_i(stid), .src_result_i(sres), .src_exception_i(sexc),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_tid), .wb_result_o(wb_res), .wb_exception_o(wb_exc),
    .empty_o(empty), .overflow_o(ovf), .perf_stall_cnt_o(perf)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int            cyc;
    int            port;
    logic [TB-1:0] tid;
    logic [63:0]   res;
    logic [EW-1:0] exc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [63:0] res_of(int s, int k);
    return 64'hC0DE_0000_0000_0000 + 64'(s * 256 + k);
  endfunction

  function automatic logic [EW-1:0] exc_of(int s, int k);
    logic [63:0] r;
    r = res_of(s, k);
    return {1'b1, ~r, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    sv = '0; stid = '0; sres = '0; sexc = '0;
  endtask

  task automatic drive(int s, logic [TB-1:0] tid, logic [63:0] res, logic [EW-1:0] exc);
    sv[s] = 1'b1;
    stid[s*TB +: TB] = tid;
    sres[s*64 +: 64] = res;
    sexc[s*EW +: EW] = exc;
  endtask

  task automatic drive_sk(int s, int k, logic [TB-1:0] tid);
    drive(s, tid, res_of(s, k), exc_of(s, k));
  endtask

  task automatic expect_wb(int c, int p, logic [TB-1:0] tid, logic [63:0] res, logic [EW-1:0] exc);
    exp_t e;
    e.cyc = c; e.port = p; e.tid = tid; e.res = res; e.exc = exc;
    exp_q.push_back(e);
  endtask

  task automatic expect_sk(int c, int p, int s, int k, logic [TB-1:0] tid);
    expect_wb(c, p, tid, res_of(s, k), exc_of(s, k));
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write port is valid.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_cmp++; n_fail++;
      $display("FAIL wb_missing: expected port %0d tid %0d at cycle %0d, not seen (now %0d)",
               exp_q[0].port, exp_q[0].tid, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (wb_valid[p]) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_fail++;
          $display("FAIL wb_unexpected: port %0d tid %0d result %0h at cycle %0d, expected none",
                   p, wb_tid[p*TB +: TB], wb_res[p*64 +: 64], cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.port != p || wb_tid[p*TB +: TB] !== e.tid || wb_res[p*64 +: 64] !== e.res ||
              wb_exc[p*EW +: EW] !== e.exc) begin
            n_fail++;
            $display("FAIL wb_data: cycle %0d got port %0d tid %0d res %0h exc %0h, expected port %0d tid %0d res %0h exc %0h",
                     cyc, p, wb_tid[p*TB +: TB], wb_res[p*64 +: 64], wb_exc[p*EW +: EW],
                     e.port, e.tid, e.res, e.exc);
          end
        end
      end else if (wb_tid[p*TB +: TB] !== '0 || wb_res[p*64 +: 64] !== '0 || wb_exc[p*EW +: EW] !== '0) begin
        n_fail++;
        $display("FAIL wb_idle_payload: port %0d cycle %0d got res %0h, expected 0", p, cyc, wb_res[p*64 +: 64]);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; clear_in();
    repeat (3) tick();
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_overflow", 64'(ovf), 64'(0));
    chk("rst_perf", 64'(perf), 64'(0));
    chk("rst_wb_result", 64'(wb_res[63:0]), 64'(0));
    rst = 1'b0;
    tick();

    // Single push on source 1
    drive(1, 3'd5, 64'hDEAD, '0);
    n = cyc;
    expect_wb(n + 2, 0, 3'd5, 64'hDEAD, '0);
    tick(); clear_in();
    chk("single_empty_pending", 64'(empty), 64'(0));
    tick();
    chk("single_empty_after", 64'(empty), 64'(1));
    repeat (3) tick();

    // Fresh reset so rr starts at 0, then all four sources at once
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int s = 0; s < NS; s++) drive_sk(s, 0, 3'(s + 4));
    n = cyc;
    expect_sk(n + 2, 0, 0, 0, 3'd4);
    expect_sk(n + 2, 1, 1, 0, 3'd5);
    expect_sk(n + 3, 0, 2, 0, 3'd6);
    expect_sk(n + 3, 1, 3, 0, 3'd7);
    tick(); clear_in();
    repeat (4) tick();
    chk("burst_perf", 64'(perf), 64'(PerfOn));
    chk("burst_empty", 64'(empty), 64'(1));

    // rr=0: sources 0,1,2 -> 0,1 then 2; rr ends at 3
    drive_sk(0, 1, 3'd1); drive_sk(1, 1, 3'd1); drive_sk(2, 1, 3'd1);
    n = cyc;
    expect_sk(n + 2, 0, 0, 1, 3'd1);
    expect_sk(n + 2, 1, 1, 1, 3'd1);
    expect_sk(n + 3, 0, 2, 1, 3'd1);
    tick(); clear_in();
    repeat (4) tick();

    // rr=3: sources 0,2,3 -> 3,0 (wrap) then 2; rr ends at 3
    drive_sk(0, 2, 3'd2); drive_sk(2, 2, 3'd2); drive_sk(3, 2, 3'd2);
    n = cyc;
    expect_sk(n + 2, 0, 3, 2, 3'd2);
    expect_sk(n + 2, 1, 0, 2, 3'd2);
    expect_sk(n + 3, 0, 2, 2, 3'd2);
    tick(); clear_in();
    repeat (4) tick();

    // Saturation: all sources for 4 cycles from rr=3; sources 1,2 drop their 4th push
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      expect_sk(n + 2 + 2 * k, 0, 3, k, 3'(k));
      expect_sk(n + 2 + 2 * k, 1, 0, k, 3'(k));
      if (k < 3) begin
        expect_sk(n + 3 + 2 * k, 0, 1, k, 3'(k));
        expect_sk(n + 3 + 2 * k, 1, 2, k, 3'(k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      clear_in();
      for (int s = 0; s < NS; s++) drive_sk(s, k, 3'(k));
      if (k == 3) chk("ovf_before_drop", 64'(ovf), 64'(0));
      tick();
    end
    clear_in();
    chk("ovf_after_drop", 64'(ovf), 64'(1));
    repeat (6) tick();
    chk("sat_perf", 64'(perf), 64'(PerfOn * 9));
    chk("sat_empty", 64'(empty), 64'(1));

    // Flush with four entries queued plus concurrent pushes
    for (int s = 0; s < NS; s++) drive_sk(s, 3, 3'd7);
    tick(); clear_in();
    chk("flush_pre_empty", 64'(empty), 64'(0));
    flush = 1'b1;
    drive_sk(0, 4, 3'd6); drive_sk(1, 4, 3'd6);
    tick();
    flush = 1'b0; clear_in();
    chk("flush_wb_valid", 64'(wb_valid), 64'(0));
    chk("flush_empty", 64'(empty), 64'(1));
    chk("flush_ovf_sticky", 64'(ovf), 64'(1));
    repeat (3) tick();

    // rr held at 1 through flush: sources 0,3 -> port0=3, port1=0
    drive_sk(0, 5, 3'd1); drive_sk(3, 5, 3'd2);
    n = cyc;
    expect_sk(n + 2, 0, 3, 5, 3'd2);
    expect_sk(n + 2, 1, 0, 5, 3'd1);
    tick(); clear_in();
    repeat (3) tick();
    chk("post_flush_perf", 64'(perf), 64'(PerfOn * 9));

    // Reset mid-operation overrides flush and pushes
    drive_sk(2, 6, 3'd3);
    tick(); clear_in();
    rst = 1'b1; flush = 1'b1;
    drive_sk(1, 6, 3'd4);
    tick();
    rst = 1'b0; flush = 1'b0; clear_in();
    chk("midrst_wb_valid", 64'(wb_valid), 64'(0));
    chk("midrst_empty", 64'(empty), 64'(1));
    chk("midrst_ovf", 64'(ovf), 64'(0));
    chk("midrst_perf", 64'(perf), 64'(0));
    repeat (4) tick();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
